// File: rtl/text_pkg.sv
// Grid geometry, control codes and FSM encoding shared by the text buffer
// and the pixel encoder.
package text_pkg;
  localparam int ROW_NUMBER  = 15;
  localparam int COL_NUMBER  = 40;
  localparam int ROW_BIT_LEN = 4;
  localparam int COL_BIT_LEN = 6;
  localparam int CHAR_ID_LEN = 8;
  localparam int TOTAL_CHAR  = 129;
  localparam int CELLS       = ROW_NUMBER * COL_NUMBER;
  localparam int ADDR_LEN    = 10;

  localparam logic [CHAR_ID_LEN-1:0] BLANK_ID   = 8'd32;
  localparam logic [CHAR_ID_LEN-1:0] FIRST_GLYPH = 8'h20;
  localparam logic [CHAR_ID_LEN-1:0] CC_LF      = 8'h0A;
  localparam logic [CHAR_ID_LEN-1:0] CC_CR      = 8'h0D;
  localparam logic [CHAR_ID_LEN-1:0] CC_BS      = 8'h08;
  localparam logic [CHAR_ID_LEN-1:0] CC_FF      = 8'h0C;

  typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_LINE} state_e;

  function automatic logic [ADDR_LEN-1:0] cell_addr(input logic [ROW_BIT_LEN-1:0] row,
                                                    input logic [COL_BIT_LEN-1:0] col);
    return ADDR_LEN'(row) * ADDR_LEN'(COL_NUMBER) + ADDR_LEN'(col);
  endfunction
endpackage

// File: rtl/text_ram.sv
// Character-cell storage: one synchronous write port, one asynchronous read port.
module text_ram
  import text_pkg::*;
(
  input  logic                   clk,
  input  logic                   we,
  input  logic [ADDR_LEN-1:0]    waddr,
  input  logic [CHAR_ID_LEN-1:0] wdata,
  input  logic [ADDR_LEN-1:0]    raddr,
  output logic [CHAR_ID_LEN-1:0] rdata
);
  logic [CHAR_ID_LEN-1:0] mem [CELLS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/text_buffer.sv
// 40x15 text store: cursor-placed writes with newline/backspace/form-feed handling,
// blanking sweeps, and a zero-latency read port for the pixel encoder.
module text_buffer
  import text_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_valid,
  input  logic [CHAR_ID_LEN-1:0] wr_char,
  output logic                   wr_ready,
  input  logic [ROW_BIT_LEN-1:0] char_row,
  input  logic [COL_BIT_LEN-1:0] char_col,
  output logic [CHAR_ID_LEN-1:0] character_id,
  output logic [ROW_BIT_LEN-1:0] cursor_row,
  output logic [COL_BIT_LEN-1:0] cursor_col,
  output logic                   busy
);
  state_e                 state_q, state_d;
  logic [ADDR_LEN-1:0]    cnt_q, cnt_d;
  logic [ROW_BIT_LEN-1:0] row_q, row_d, next_row;
  logic [COL_BIT_LEN-1:0] col_q, col_d;
  logic                   we;
  logic [ADDR_LEN-1:0]    waddr, raddr;
  logic [CHAR_ID_LEN-1:0] wdata, rdata;
  logic                   rd_in_range;

  assign next_row = (row_q == ROW_BIT_LEN'(ROW_NUMBER - 1)) ? '0 : row_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    col_d   = col_q;
    we      = 1'b0;
    waddr   = cell_addr(row_q, col_q);
    wdata   = BLANK_ID;
    case (state_q)
      CLR_ALL: begin
        we    = 1'b1;
        waddr = cnt_q;
        if (cnt_q == ADDR_LEN'(CELLS - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CLR_LINE: begin
        // row_q already points at the freshly entered line
        we    = 1'b1;
        waddr = cell_addr(row_q, cnt_q[COL_BIT_LEN-1:0]);
        if (cnt_q == ADDR_LEN'(COL_NUMBER - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (wr_valid) begin
          if (wr_char >= FIRST_GLYPH && wr_char < CHAR_ID_LEN'(TOTAL_CHAR)) begin
            we    = 1'b1;
            wdata = wr_char;
            if (col_q == COL_BIT_LEN'(COL_NUMBER - 1)) begin
              col_d   = '0;
              row_d   = next_row;
              cnt_d   = '0;
              state_d = CLR_LINE;
            end else begin
              col_d = col_q + 1'b1;
            end
          end else begin
            case (wr_char)
              CC_LF, CC_CR: begin
                col_d   = '0;
                row_d   = next_row;
                cnt_d   = '0;
                state_d = CLR_LINE;
              end
              CC_BS: begin
                if (col_q != '0) begin
                  col_d = col_q - 1'b1;
                  we    = 1'b1;
                  waddr = cell_addr(row_q, col_q - 1'b1);
                end
              end
              CC_FF: begin
                row_d   = '0;
                col_d   = '0;
                cnt_d   = '0;
                state_d = CLR_ALL;
              end
              default: ;
            endcase
          end
        end
      end
      default: begin
        state_d = CLR_ALL;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLR_ALL;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Out-of-range coordinates would alias other cells, so they never reach the RAM.
  assign rd_in_range  = (char_row < ROW_BIT_LEN'(ROW_NUMBER)) && (char_col < COL_BIT_LEN'(COL_NUMBER));
  assign raddr        = rd_in_range ? cell_addr(char_row, char_col) : '0;
  assign character_id = rd_in_range ? rdata : BLANK_ID;

  text_ram u_ram (
    .clk  (clk),
    .we   (we && !reset),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(raddr),
    .rdata(rdata)
  );

  assign wr_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign cursor_row = row_q;
  assign cursor_col = col_q;
endmodule
